// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: one full-subtractor cell reused LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {difference, borrow_out} of a 1-bit full subtractor.
  function automatic logic [1:0] fsub(input logic ai, input logic bi, input logic ci);
    fsub = {ai ^ bi ^ ci, (~ai & (bi ^ ci)) | (bi & ci)};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             c_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       fs_s;
  logic             d_s;
  logic             c_nxt_s;

  assign fs_s    = fsub(a_r[0], b_r[0], c_r);
  assign d_s     = fs_s[1];
  assign c_nxt_s = fs_s[0];

  // Control FSM, serial datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      c_r     <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borr    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_r)
        RUN: begin
          a_r   <= {1'b0, a_r[WIDTH-1:1]};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          res_r <= {d_s, res_r[WIDTH-1:1]};
          c_r   <= c_nxt_s;
          if (cnt_r == LAST_BIT) begin
            // Operand LSBs now hold the original sign bits.
            diff    <= {d_s, res_r[WIDTH-1:1]};
            borr    <= c_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= (a_r[0] != b_r[0]) && (d_s != a_r[0]);
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            c_r     <= bin;
            res_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: scoreboard of expected results plus per-scenario tasks.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borr;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int           errors = 0;
  int           checks = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] last_d = '0;
  logic         last_br = 1'b0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borr  (borr)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv);
    logic [W:0] t;
    exp_t m;
    t    = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, biv};
    m.d  = t[W-1:0];
    m.br = t[W];
    m.ov = (av[W-1] != bv[W-1]) && (t[W-1] != av[W-1]);
    return m;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done diff=%h", diff);
      end else begin
        mon_e = sb.pop_front();
        if (diff !== mon_e.d || borr !== mon_e.br) begin
          errors++;
          $display("FAIL sb_result got diff=%h borr=%b exp diff=%h borr=%b", diff, borr, mon_e.d, mon_e.br);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== mon_e.ov) begin
          errors++;
          $display("FAIL sb_ovf got=%b exp=%b", ovf, mon_e.ov);
        end
`endif
      end
    end
  end

  // Called at a negedge: presents a request for one cycle, returns one negedge later.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv, output exp_t e);
    start = 1'b1;
    a = av;
    b = bv;
    bin = biv;
    e = model(av, bv, biv);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  // Checks WIDTH busy cycles (outputs holding the previous result) then the done cycle.
  task automatic wait_done(input exp_t e, input int inject_at);
    for (int i = 1; i <= W; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || diff !== last_d || borr !== last_br) begin
        errors++;
        $display("FAIL run_cycle%0d got busy=%b done=%b diff=%h borr=%b exp busy=1 done=0 diff=%h borr=%b",
                 i, busy, done, diff, borr, last_d, last_br);
      end
      if (i == inject_at) begin
        start = 1'b1;
        a = W'(1);
        b = W'(1);
        bin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || diff !== e.d || borr !== e.br) begin
      errors++;
      $display("FAIL done_cycle got busy=%b done=%b diff=%h borr=%b exp busy=0 done=1 diff=%h borr=%b",
               busy, done, diff, borr, e.d, e.br);
    end
    last_d = e.d;
    last_br = e.br;
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== last_d || borr !== last_br) begin
        errors++;
        $display("FAIL idle_hold got busy=%b done=%b diff=%h borr=%b exp busy=0 done=0 diff=%h borr=%b",
                 busy, done, diff, borr, last_d, last_br);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borr !== 1'b0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b diff=%h borr=%b exp all zero", busy, done, diff, borr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(2);
  endtask

  task automatic test_values();
    logic [W-1:0] ta[4] = '{8'h05, 8'h03, 8'h00, 8'h80};
    logic [W-1:0] tb[4] = '{8'h03, 8'h05, 8'h00, 8'h01};
    logic         tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i], tc[i], e);
      wait_done(e, 0);
      check_idle(2);
    end
  endtask

  task automatic test_start_in_run();
    exp_t e;
    launch(8'h80, 8'h01, 1'b0, e);
    wait_done(e, 3);
    check_idle(4);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    launch(8'h03, 8'h05, 1'b0, e);
    wait_done(e, 0);
    launch(8'h09, 8'h04, 1'b0, e);
    wait_done(e, 0);
    check_idle(2);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    exp_t dropped;
    launch(8'h05, 8'h03, 1'b0, e);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borr !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b diff=%h borr=%b exp all zero", busy, done, diff, borr);
    end
    dropped = sb.pop_back();
    last_d = '0;
    last_br = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(3);
    launch(8'h09, 8'h04, 1'b0, e);
    wait_done(e, 0);
    check_idle(2);
  endtask

  initial begin
    test_reset();
    test_values();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
